// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage for the LEGv8 pipeline feeding the 64-bit ALU.
// Latches the decoded instruction and register-file read data, decodes the
// opcode into ALU function and memory/writeback controls, builds immediates
// and applies EX/MEM and MEM/WB forwarding to the ALU operands and store data.
//
// Ports:
//   CLK, RST            rising-edge clock, synchronous active-high reset
//   STALL, FLUSH        hazard-unit hold / bubble requests
//   ID_VALID, ID_INSTR  instruction presented by decode
//   ID_RD1, ID_RD2      register-file values of Rn and Rm/Rt
//   MEM_FWD_*, WB_FWD_* forwarding sources from EX/MEM and MEM/WB
//   ALU_A, ALU_B        forwarded ALU operands
//   ALU_CTRL            ALU function (0 AND, 1 ORR, 2 ADD, 6 SUB, 7 PASS B)
//   EX_STORE_DATA       forwarded Rt value for STUR
//   EX_RD, EX_VALID     destination register and stage-valid flag
//   EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE, EX_BRANCH_Z  stage controls
//   EX_ILLEGAL          one-cycle pulse when a valid undecodable word is dropped
module id_ex_stage #(
  parameter int unsigned XLEN       = 64,
  parameter bit          FWD_ENABLE = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL,
  input  logic            FLUSH,
  input  logic            ID_VALID,
  input  logic [31:0]     ID_INSTR,
  input  logic [XLEN-1:0] ID_RD1,
  input  logic [XLEN-1:0] ID_RD2,
  input  logic            MEM_FWD_EN,
  input  logic [4:0]      MEM_FWD_REG,
  input  logic [XLEN-1:0] MEM_FWD_DATA,
  input  logic            WB_FWD_EN,
  input  logic [4:0]      WB_FWD_REG,
  input  logic [XLEN-1:0] WB_FWD_DATA,
  output logic [XLEN-1:0] ALU_A,
  output logic [XLEN-1:0] ALU_B,
  output logic [3:0]      ALU_CTRL,
  output logic [XLEN-1:0] EX_STORE_DATA,
  output logic [4:0]      EX_RD,
  output logic            EX_VALID,
  output logic            EX_REG_WRITE,
  output logic            EX_MEM_READ,
  output logic            EX_MEM_WRITE,
  output logic            EX_BRANCH_Z,
  output logic            EX_ILLEGAL
);

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] XZR = 5'd31;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [9:0]  OP_ADDI = 10'h244;
  localparam logic [9:0]  OP_SUBI = 10'h344;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;

  localparam logic [3:0] CTRL_AND  = 4'd0;
  localparam logic [3:0] CTRL_ORR  = 4'd1;
  localparam logic [3:0] CTRL_ADD  = 4'd2;
  localparam logic [3:0] CTRL_SUB  = 4'd6;
  localparam logic [3:0] CTRL_PASS = 4'd7;

  // decode outputs
  logic             dec_legal;
  logic [3:0]       dec_ctrl;
  logic             dec_rw, dec_mr, dec_mw, dec_bz, dec_imm_sel;
  logic [XLEN-1:0]  dec_imm;
  logic [REG_W-1:0] dec_src2;

  // stage registers
  logic             valid_q, illegal_q;
  logic [3:0]       ctrl_q;
  logic             rw_q, mr_q, mw_q, bz_q, imm_sel_q;
  logic [XLEN-1:0]  imm_q, rd1_q, rd2_q;
  logic [REG_W-1:0] src1_q, src2_q, rd_q;

  logic [XLEN-1:0]  opa, opb;

  // opcode decode; src2 is Rm for R-type and Rt otherwise
  always_comb begin
    dec_legal   = 1'b1;
    dec_ctrl    = CTRL_ADD;
    dec_rw      = 1'b0;
    dec_mr      = 1'b0;
    dec_mw      = 1'b0;
    dec_bz      = 1'b0;
    dec_imm_sel = 1'b0;
    dec_imm     = '0;
    dec_src2    = ID_INSTR[4:0];
    if (ID_INSTR[31:21] == OP_ADD || ID_INSTR[31:21] == OP_SUB ||
        ID_INSTR[31:21] == OP_AND || ID_INSTR[31:21] == OP_ORR) begin
      dec_rw   = 1'b1;
      dec_src2 = ID_INSTR[20:16];
      case (ID_INSTR[31:21])
        OP_SUB:  dec_ctrl = CTRL_SUB;
        OP_AND:  dec_ctrl = CTRL_AND;
        OP_ORR:  dec_ctrl = CTRL_ORR;
        default: dec_ctrl = CTRL_ADD;
      endcase
    end else if (ID_INSTR[31:22] == OP_ADDI || ID_INSTR[31:22] == OP_SUBI) begin
      dec_rw      = 1'b1;
      dec_imm_sel = 1'b1;
      dec_imm     = {{(XLEN-12){1'b0}}, ID_INSTR[21:10]};
      dec_ctrl    = (ID_INSTR[31:22] == OP_SUBI) ? CTRL_SUB : CTRL_ADD;
    end else if (ID_INSTR[31:21] == OP_LDUR || ID_INSTR[31:21] == OP_STUR) begin
      dec_imm_sel = 1'b1;
      dec_imm     = {{(XLEN-9){ID_INSTR[20]}}, ID_INSTR[20:12]};
      dec_mr      = (ID_INSTR[31:21] == OP_LDUR);
      dec_mw      = (ID_INSTR[31:21] == OP_STUR);
      dec_rw      = (ID_INSTR[31:21] == OP_LDUR);
    end else if (ID_INSTR[31:24] == OP_CBZ) begin
      dec_ctrl = CTRL_PASS;
      dec_bz   = 1'b1;
    end else begin
      dec_legal = 1'b0;
    end
  end

  // stage registers: RST > FLUSH > STALL > load
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      ctrl_q    <= '0;
      rw_q      <= 1'b0;
      mr_q      <= 1'b0;
      mw_q      <= 1'b0;
      bz_q      <= 1'b0;
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      rd_q      <= '0;
    end else if (FLUSH) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      ctrl_q    <= '0;
      rw_q      <= 1'b0;
      mr_q      <= 1'b0;
      mw_q      <= 1'b0;
      bz_q      <= 1'b0;
    end else if (STALL) begin
      // the illegal flag is an event pulse, so it does not survive a hold
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= ID_VALID & dec_legal;
      illegal_q <= ID_VALID & ~dec_legal;
      ctrl_q    <= dec_legal ? dec_ctrl : 4'd0;
      rw_q      <= ID_VALID & dec_legal & dec_rw;
      mr_q      <= ID_VALID & dec_legal & dec_mr;
      mw_q      <= ID_VALID & dec_legal & dec_mw;
      bz_q      <= ID_VALID & dec_legal & dec_bz;
      imm_sel_q <= dec_imm_sel;
      imm_q     <= dec_imm;
      rd1_q     <= ID_RD1;
      rd2_q     <= ID_RD2;
      src1_q    <= ID_INSTR[9:5];
      src2_q    <= dec_src2;
      rd_q      <= ID_INSTR[4:0];
    end
  end

  // XZR reads as zero; MEM result beats WB result when both match
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [XLEN-1:0]  latched,
    input logic             m_en,
    input logic [REG_W-1:0] m_reg,
    input logic [XLEN-1:0]  m_data,
    input logic             w_en,
    input logic [REG_W-1:0] w_reg,
    input logic [XLEN-1:0]  w_data
  );
    if (src == XZR)                                fwd_sel = '0;
    else if (FWD_ENABLE && m_en && (m_reg == src)) fwd_sel = m_data;
    else if (FWD_ENABLE && w_en && (w_reg == src)) fwd_sel = w_data;
    else                                           fwd_sel = latched;
  endfunction

  assign opa = fwd_sel(src1_q, rd1_q, MEM_FWD_EN, MEM_FWD_REG, MEM_FWD_DATA,
                       WB_FWD_EN, WB_FWD_REG, WB_FWD_DATA);
  assign opb = fwd_sel(src2_q, rd2_q, MEM_FWD_EN, MEM_FWD_REG, MEM_FWD_DATA,
                       WB_FWD_EN, WB_FWD_REG, WB_FWD_DATA);

  // everything is gated by valid so a bubble or reset presents all zeros
  assign ALU_A         = valid_q ? opa : '0;
  assign ALU_B         = valid_q ? (imm_sel_q ? imm_q : opb) : '0;
  assign EX_STORE_DATA = valid_q ? opb : '0;
  assign ALU_CTRL      = valid_q ? ctrl_q : 4'd0;
  assign EX_RD         = valid_q ? rd_q : 5'd0;
  assign EX_VALID      = valid_q;
  assign EX_REG_WRITE  = valid_q & rw_q;
  assign EX_MEM_READ   = valid_q & mr_q;
  assign EX_MEM_WRITE  = valid_q & mw_q;
  assign EX_BRANCH_Z   = valid_q & bz_q;
  assign EX_ILLEGAL    = illegal_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage feeding the 64-bit ALU of the LEGv8 pipeline.
- Latches the decoded instruction and the register-file read data, and decodes the opcode into ALU_CTRL and memory/writeback control.
- Builds the immediates and applies EX/MEM and MEM/WB operand forwarding to produce the ALU A/B operands and the store data.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- XLEN, 64, operand/data width; must match the ALU.
- FWD_ENABLE, 1, 1 = forwarding active; 0 = latched operands pass through unforwarded.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- STALL  input  1  hold all stage registers this cycle
- FLUSH  input  1  load a bubble this cycle
- ID_VALID  input  1  ID holds a real instruction
- ID_INSTR  input  32  instruction word
- ID_RD1  input  XLEN  regfile value of Rn (instr[9:5])
- ID_RD2  input  XLEN  regfile value of Rm (instr[20:16]) for R-type, Rt (instr[4:0]) for STUR/CBZ
- MEM_FWD_EN  input  1  EX/MEM stage writes a register
- MEM_FWD_REG  input  5  EX/MEM destination
- MEM_FWD_DATA  input  XLEN  EX/MEM result
- WB_FWD_EN  input  1  MEM/WB stage writes a register
- WB_FWD_REG  input  5  MEM/WB destination
- WB_FWD_DATA  input  XLEN  MEM/WB result
- ALU_A  output  XLEN  ALU operand A
- ALU_B  output  XLEN  ALU operand B
- ALU_CTRL  output  4  ALU function: 0 AND, 1 ORR, 2 ADD, 6 SUB, 7 PASS B
- EX_STORE_DATA  output  XLEN  forwarded Rt value for STUR
- EX_RD  output  5  destination register
- EX_VALID  output  1  stage holds a valid instruction
- EX_REG_WRITE  output  1  instruction writes Rd
- EX_MEM_READ  output  1  LDUR
- EX_MEM_WRITE  output  1  STUR
- EX_BRANCH_Z  output  1  CBZ
- EX_ILLEGAL  output  1  pulses 1 cycle when a valid but undecodable instruction is dropped

Behaviour:
- Edge priority: RST > FLUSH > STALL > load.
- RST: every register and every output is 0 on the next edge, including EX_VALID, all controls, ALU_CTRL, ALU_A, ALU_B and EX_STORE_DATA. Reset mid-stall or mid-flush still clears the stage.
- FLUSH: EX_VALID is 0 and all controls are 0 next cycle. Data registers may hold any value, but outputs are gated.
- STALL without FLUSH: all registers hold. The forwarding muxes stay live, so the operands track the current forwarding inputs.
- Load: latency is 1 cycle. An instruction present at edge k drives the outputs after edge k.
- Decode, on the 11-bit opcode instr[31:21] unless noted:
  - ADD 0x458: CTRL=2, B=Rm, REG_WRITE.
  - SUB 0x658: CTRL=6, B=Rm, REG_WRITE.
  - AND 0x450: CTRL=0, B=Rm, REG_WRITE.
  - ORR 0x550: CTRL=1, B=Rm, REG_WRITE.
  - ADDI, instr[31:22]=0x244: CTRL=2, B=zero-extended instr[21:10], REG_WRITE.
  - SUBI, instr[31:22]=0x344: CTRL=6, B=zero-extended instr[21:10], REG_WRITE.
  - LDUR 0x7C2: CTRL=2, B=sign-extended instr[20:12], MEM_READ, REG_WRITE, EX_RD=Rt.
  - STUR 0x7C0: CTRL=2, B=sign-extended instr[20:12], MEM_WRITE, no REG_WRITE.
  - CBZ, instr[31:24]=0xB4: CTRL=7, B=Rt value, BRANCH_Z, no REG_WRITE.
  - Anything else with ID_VALID=1: loaded as a bubble with EX_ILLEGAL=1 for one cycle.
  - ID_VALID=0: loaded as a bubble with EX_ILLEGAL=0.
- Register 31 is XZR:
  - Source index 31 reads as 0, regardless of ID_RD1/ID_RD2 or forwarding.
  - A write with Rd=31 still asserts REG_WRITE; the regfile discards it.
- Forwarding (combinational from the latched source indices), per source operand:
  - MEM_FWD_EN and MEM_FWD_REG==src and src!=31 → MEM_FWD_DATA.
  - Else WB_FWD_EN and WB_FWD_REG==src and src!=31 → WB_FWD_DATA.
  - Else the latched value.
  - MEM has priority when both stages match.
- Forwarding targets:
  - Applies to A (Rn) and to register-sourced B (Rm, or Rt for CBZ).
  - Applies to EX_STORE_DATA (Rt).
  - Never applies to immediate-sourced B.
- Outputs are gated when EX_VALID=0:
  - ALU_CTRL, REG_WRITE, MEM_READ, MEM_WRITE and BRANCH_Z are 0.
  - ALU_A and ALU_B are don't-care, but the bench expects 0 after reset.

Test Plan:
- Reset then idle → all outputs 0; EX_VALID=0.
- ADD X3,X1,X2 (0x8B020023), RD1=10, RD2=20, no forwarding → next cycle A=10, B=20, CTRL=2, EX_RD=3, REG_WRITE=1.
- ADDI X4,X1,#5 (0x91001424), RD1=7, with MEM_FWD_EN=1, MEM_FWD_REG=1, MEM_FWD_DATA=100, WB matching X1 with 55 → A=100 (MEM wins), B=5.
- LDUR X5,[X1,#-8] (0xF85F8025) → B=0xFFFFFFFFFFFFFFF8, CTRL=2, MEM_READ=1, EX_RD=5. With STALL held 3 cycles, outputs stay constant.
- CBZ X7 (0xB4000047), RD2=0 → CTRL=7, B=0, BRANCH_Z=1. Same cycle FLUSH=1 on the next instruction → EX_VALID=0 and all controls 0.
- Instruction 0x00000000 with ID_VALID=1 → bubble, EX_ILLEGAL=1 for exactly one cycle. Source X31 with a forwarding match on reg 31 → operand 0.
